// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^8) arithmetic and shared constants for the t=1 RS decoder
package rs_pkg;

    localparam int N_DEF = 16;
    localparam int K_DEF = 14;

    localparam logic [8:0] PRIM_POLY = 9'h11D;
    localparam logic [7:0] GF_A      = 8'h02;
    localparam logic [7:0] GF_A_INV  = 8'h8E;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_WAIT,
        OUT_RUN
    } out_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ sh;
            sh = sh[7] ? ((sh << 1) ^ PRIM_POLY[7:0]) : (sh << 1);
        end
        return acc;
    endfunction

    // With a constant c this folds to a fixed XOR network.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] c);
        return gf_mul(x, c);
    endfunction

    function automatic logic [7:0] gf_pow_a(input int e);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < e; i++) v = gf_mul(v, GF_A);
        return v;
    endfunction

endpackage

// File: rtl/rs_syndrome.sv
// rtl/rs_syndrome.sv - Horner accumulators for S0=r(1), S1=r(a), latched at frame end
module rs_syndrome
    import rs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       frame_end,
    output logic [7:0] s0_next,
    output logic [7:0] s1_next,
    output logic [7:0] s0,
    output logic [7:0] s1
);

    logic [7:0] acc0;
    logic [7:0] acc1;

    always_comb begin
        s0_next = acc0 ^ in_data;
        s1_next = gf_mul_const(acc1, GF_A) ^ in_data;
    end

    // The final symbol is folded in combinationally so clear and latch share one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc0 <= '0;
            acc1 <= '0;
            s0   <= '0;
            s1   <= '0;
        end else if (in_valid) begin
            if (frame_end) begin
                acc0 <= '0;
                acc1 <= '0;
                s0   <= s0_next;
                s1   <= s1_next;
            end else begin
                acc0 <= s0_next;
                acc1 <= s1_next;
            end
        end
    end

endmodule

// File: rtl/rsdec_t1.sv
// rtl/rsdec_t1.sv - RS(N,N-2) t=1 decoder: syndromes, ping-pong frame buffer, corrected output
module rsdec_t1
    import rs_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_fixed,
    output logic       out_uncorr
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] IN_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(K - 1);
    localparam logic [7:0]    A_N1     = gf_pow_a(N - 1);

    logic [7:0]    mem [2][N];
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic          frame_end;
    logic [7:0]    s0_next, s1_next, s0_l, s1_l;
    logic [7:0]    loc;
    logic          clean_l, par_l, sticky;
    logic [7:0]    rd_sym;
    logic          match;
    logic          last_sym;
    out_state_t    state_q, state_d;

    assign frame_end = in_valid && (in_cnt == IN_LAST);

    rs_syndrome u_syn (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .frame_end (frame_end),
        .s0_next   (s0_next),
        .s1_next   (s1_next),
        .s0        (s0_l),
        .s1        (s1_l)
    );

    always_ff @(posedge clk) begin
        if (in_valid) mem[wr_bank][in_cnt] <= in_data;
    end

    always_comb begin
        rd_sym   = mem[rd_bank][out_cnt];
        match    = (s0_l != 8'h00) && (s1_l == loc);
        last_sym = (out_cnt == OUT_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_IDLE: if (frame_end) state_d = OUT_WAIT;
            OUT_WAIT: state_d = OUT_RUN;
            OUT_RUN:  if (last_sym) state_d = OUT_IDLE;
            default:  state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OUT_IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            loc        <= '0;
            clean_l    <= 1'b0;
            par_l      <= 1'b0;
            sticky     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_fixed  <= 1'b0;
            out_uncorr <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_valid) begin
                in_cnt <= frame_end ? '0 : in_cnt + 1'b1;
                if (frame_end) wr_bank <= ~wr_bank;
            end
            // Locator starts at the first data position (x^(N-1)) and walks down one per symbol.
            if (frame_end) begin
                rd_bank <= wr_bank;
                loc     <= gf_mul_const(s0_next, A_N1);
                clean_l <= (s0_next == 8'h00) && (s1_next == 8'h00);
                par_l   <= (s0_next != 8'h00) &&
                           ((s1_next == s0_next) || (s1_next == gf_mul_const(s0_next, GF_A)));
                sticky  <= 1'b0;
            end else if (state_q == OUT_RUN) begin
                loc <= gf_mul_const(loc, GF_A_INV);
                if (match) sticky <= 1'b1;
            end
            out_cnt <= (state_q == OUT_RUN) ? out_cnt + 1'b1 : '0;
            if (state_q == OUT_RUN) begin
                out_valid  <= 1'b1;
                out_data   <= match ? (rd_sym ^ s0_l) : rd_sym;
                out_fixed  <= match;
                out_last   <= last_sym;
                out_uncorr <= last_sym && !(clean_l || par_l || sticky || match);
            end else begin
                out_valid  <= 1'b0;
                out_data   <= '0;
                out_fixed  <= 1'b0;
                out_last   <= 1'b0;
                out_uncorr <= 1'b0;
            end
        end
    end

endmodule
